// File: rtl/dmem_responder_pkg.sv
// Shared types for the dmem responder: bus bundles, array ports, controller state.
package dmem_wires;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_type;

    typedef struct packed {
        logic        wen;
        logic [3:0]  wstrb;
        logic [29:0] waddr;
        logic [29:0] raddr;
        logic [31:0] wdata;
    } dmem_array_in_type;

    typedef struct packed {
        logic [31:0] rdata;
    } dmem_array_out_type;

    typedef struct packed {
        dmem_state_type state;
        logic [15:0]    count;
        logic [29:0]    addr;
        logic           rd;
        logic           ready;
        logic [31:0]    rdata;
    } reg_type;

    localparam reg_type init_reg = '{
        state: IDLE,
        count: '0,
        addr:  '0,
        rd:    1'b0,
        ready: 1'b0,
        rdata: '0
    };

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Byte-strobed word array: synchronous write, asynchronous read, no reset.
module dmem_responder_array
    import dmem_wires::*;
#(
    parameter int dmem_depth = 10
) (
    input  logic               clk,
    input  dmem_array_in_type  req,
    output dmem_array_out_type rsp
);

    localparam int words = 1 << dmem_depth;

    logic [31:0] mem [words] = '{default: '0};
    logic        unused_bits;

    always_ff @(posedge clk) begin
        if (req.wen) begin
            for (int i = 0; i < 4; i++) begin
                if (req.wstrb[i]) begin
                    mem[req.waddr[dmem_depth-1:0]][8*i +: 8] <= req.wdata[8*i +: 8];
                end
            end
        end
    end

    assign rsp.rdata = mem[req.raddr[dmem_depth-1:0]];

    assign unused_bits = ^{req.waddr[29:dmem_depth], req.raddr[29:dmem_depth]};

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with configurable wait states over a word array.
// Define DMEM_STALL_EN to add LFSR-driven random response deferral.
module dmem_responder
    import dmem_wires::*;
#(
    parameter int          dmem_depth     = 10,
    parameter int          dmem_latency   = 1,
    parameter logic [15:0] dmem_lfsr_seed = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out
);

    reg_type            r;
    reg_type            rin;
    dmem_array_in_type  array_req;
    dmem_array_out_type array_rsp;
    logic [29:0]        index;
    logic               accept;
    logic               is_read;
    logic               go_resp;
    logic               stall;
    logic               unused_bits;

`ifdef DMEM_STALL_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_nx;

    assign lfsr_nx = lfsr_step(lfsr);
    // ready for the coming cycle is judged by the lfsr value of that cycle
    assign stall = lfsr_nx[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= dmem_lfsr_seed;
        end else begin
            lfsr <= lfsr_nx;
        end
    end
`else
    logic [15:0] unused_seed;

    assign unused_seed = dmem_lfsr_seed;
    assign stall = 1'b0;
`endif

    assign index = {{(30-dmem_depth){1'b0}}, dmem_in.mem_addr[dmem_depth+1:2]};

    assign accept = dmem_in.mem_valid &&
                    (r.state == IDLE || (r.state == RESP && r.ready));

    assign is_read = !dmem_in.mem_fence && (dmem_in.mem_wstrb == 4'h0);

    assign array_req = '{
        wen:   accept && !dmem_in.mem_fence && (dmem_in.mem_wstrb != 4'h0),
        wstrb: dmem_in.mem_wstrb,
        waddr: index,
        raddr: accept ? index : r.addr,
        wdata: dmem_in.mem_wdata
    };

    dmem_responder_array #(
        .dmem_depth(dmem_depth)
    ) u_array (
        .clk(clk),
        .req(array_req),
        .rsp(array_rsp)
    );

    always_comb begin
        rin       = r;
        rin.ready = 1'b0;
        rin.rdata = '0;
        go_resp   = 1'b0;

        unique case (r.state)
            IDLE: rin.state = IDLE;
            WAIT: begin
                rin.count = r.count - 16'd1;
                go_resp   = (rin.count == 16'd0);
            end
            RESP: begin
                if (r.ready) begin
                    rin.state = IDLE;
                end else begin
                    go_resp = 1'b1;
                end
            end
        endcase

        if (accept) begin
            rin.addr  = index;
            rin.rd    = is_read;
            rin.count = 16'(dmem_latency);
            rin.state = WAIT;
            go_resp   = (dmem_latency == 0);
        end

        if (go_resp) begin
            rin.state = RESP;
            rin.ready = !stall;
            if (!stall && rin.rd) begin
                rin.rdata = array_rsp.rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= init_reg;
        end else begin
            r <= rin;
        end
    end

    assign dmem_out.mem_ready = r.ready;
    assign dmem_out.mem_rdata = r.rdata;

    assign unused_bits = ^{dmem_in.mem_instr,
                           dmem_in.mem_addr[31:dmem_depth+2],
                           dmem_in.mem_addr[1:0]};

`ifndef SYNTHESIS
    // initiators must not present a request while a response is pending
    no_valid_in_wait: assert property (
        @(posedge clk) disable iff (rst)
        !(dmem_in.mem_valid && r.state == WAIT)
    );
`endif

endmodule
